// File: rtl/string_to_board.sv
// ASCII board-frame parser: turns the text printer's '|'/'-'/space padded tile grid and
// "score: N" line back into a 16-tile board word and a score value.
module string_to_board #(
    parameter int TILE_W  = 20,
    parameter int SCORE_W = 21
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            char_in,
    input  logic                  char_valid,
    output logic                  char_ready,
    output logic [16*TILE_W-1:0]  board,
    output logic                  board_valid,
    output logic [SCORE_W-1:0]    score,
    output logic                  score_valid,
    output logic                  parse_err,
    output logic [4:0]            tile_cnt
);

    localparam int AW = (TILE_W > SCORE_W) ? TILE_W : SCORE_W;
    localparam int NW = AW + 4;
    localparam logic [NW-1:0] TILE_MAX  = {{(NW-TILE_W){1'b0}}, {TILE_W{1'b1}}};
    localparam logic [NW-1:0] SCORE_MAX = {{(NW-SCORE_W){1'b0}}, {SCORE_W{1'b1}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_NUM,
        S_GAP,
        S_COMMIT,
        S_SHDR,
        S_SNUM
    } state_t;

    state_t                r_state;
    logic [AW-1:0]         r_acc;
    logic [16*TILE_W-1:0]  r_shadow;
    logic [4:0]            r_tile_cnt;
    logic [16*TILE_W-1:0]  r_board;
    logic [SCORE_W-1:0]    r_score;
    logic                  r_board_valid;
    logic                  r_score_valid;
    logic                  r_parse_err;
    logic                  r_char_ready;

    logic                  w_take;
    logic                  w_is_dig;
    logic                  w_is_sep;
    logic                  w_is_print;
    logic                  w_is_eol;
    logic [3:0]            w_digit;
    logic [NW-1:0]         w_acc_wide;
    logic [NW-1:0]         w_acc_next;
    logic [AW-1:0]         w_acc_first;
    logic                  w_err;

    assign w_take     = char_valid & r_char_ready;
    assign w_is_dig   = (char_in >= 8'h30) && (char_in <= 8'h39);
    assign w_is_sep   = (char_in == 8'h20) || (char_in == 8'h7C) || (char_in == 8'h2D) ||
                        (char_in == 8'h0D) || (char_in == 8'h0A);
    assign w_is_print = (char_in >= 8'h20) && (char_in <= 8'h7E);
    assign w_is_eol   = (char_in == 8'h0A) || (char_in == 8'h0D);
    assign w_digit    = char_in[3:0];

    // acc*10 + d as shift-and-add, widened by 4 bits so an overflow is still visible
    assign w_acc_wide  = {4'b0000, r_acc};
    assign w_acc_next  = (w_acc_wide << 3) + (w_acc_wide << 1) + {{(NW-4){1'b0}}, w_digit};
    assign w_acc_first = {{(AW-4){1'b0}}, w_digit};

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        w_err = 1'b0;
        if (w_take) begin
            case (r_state)
                S_IDLE:  w_err = !(w_is_dig || w_is_sep || (char_in == 8'h73));
                S_NUM:   w_err = w_is_dig ? (w_acc_next > TILE_MAX) : !w_is_sep;
                S_GAP:   w_err = !(w_is_dig || w_is_sep);
                S_SHDR:  w_err = !w_is_dig && !w_is_print;
                S_SNUM:  w_err = w_is_dig ? (w_acc_next > SCORE_MAX) : !w_is_eol;
                default: w_err = 1'b0;
            endcase
        end
    end

    // NOTE: state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_acc         <= '0;
            // NOTE: the shadow tile store is reset too, so no X can ever reach the board.
            r_shadow      <= '0;
            r_tile_cnt    <= '0;
            r_board       <= '0;
            r_score       <= '0;
            r_board_valid <= 1'b0;
            r_score_valid <= 1'b0;
            r_parse_err   <= 1'b0;
            r_char_ready  <= 1'b1;
        end else begin
            r_board_valid <= 1'b0;
            r_score_valid <= 1'b0;
            r_parse_err   <= 1'b0;

            if (w_err) begin
                r_parse_err  <= 1'b1;
                r_state      <= S_IDLE;
                r_tile_cnt   <= '0;
                r_acc        <= '0;
                r_char_ready <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: if (w_take) begin
                        if (w_is_dig) begin
                            r_acc   <= w_acc_first;
                            r_state <= S_NUM;
                        end else if (char_in == 8'h73) begin
                            r_state <= S_SHDR;
                        end
                    end
                    S_NUM: if (w_take) begin
                        if (w_is_dig) begin
                            r_acc <= w_acc_next[AW-1:0];
                        end else begin
                            r_shadow[r_tile_cnt[3:0]*TILE_W +: TILE_W] <= r_acc[TILE_W-1:0];
                            r_tile_cnt <= r_tile_cnt + 5'd1;
                            if (r_tile_cnt == 5'd15) begin
                                r_state      <= S_COMMIT;
                                r_char_ready <= 1'b0;
                            end else begin
                                r_state <= S_GAP;
                            end
                        end
                    end
                    S_GAP: if (w_take && w_is_dig) begin
                        r_acc   <= w_acc_first;
                        r_state <= S_NUM;
                    end
                    S_COMMIT: begin
                        r_board       <= r_shadow;
                        r_board_valid <= 1'b1;
                        r_tile_cnt    <= '0;
                        r_acc         <= '0;
                        r_char_ready  <= 1'b1;
                        r_state       <= S_IDLE;
                    end
                    S_SHDR: if (w_take && w_is_dig) begin
                        r_acc   <= w_acc_first;
                        r_state <= S_SNUM;
                    end
                    S_SNUM: if (w_take) begin
                        if (w_is_dig) begin
                            r_acc <= w_acc_next[AW-1:0];
                        end else begin
                            r_score       <= r_acc[SCORE_W-1:0];
                            r_score_valid <= 1'b1;
                            r_acc         <= '0;
                            r_state       <= S_IDLE;
                        end
                    end
                    default: begin
                        r_state      <= S_IDLE;
                        r_char_ready <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign char_ready  = r_char_ready;
    assign board       = r_board;
    assign board_valid = r_board_valid;
    assign score       = r_score;
    assign score_valid = r_score_valid;
    assign parse_err   = r_parse_err;
    assign tile_cnt    = r_tile_cnt;

endmodule

// File: tb/tb_string_to_board.sv
// Directed bench for string_to_board: full frames, overflow limits, error recovery,
// the COMMIT stall under back-to-back traffic, and mid-frame reset.
module tb_string_to_board;

    logic          clk;
    logic          rst_n;
    logic [7:0]    char_in;
    logic          char_valid;
    logic          char_ready;
    logic [319:0]  board;
    logic          board_valid;
    logic [20:0]   score;
    logic          score_valid;
    logic          parse_err;
    logic [4:0]    tile_cnt;

    string_to_board #(.TILE_W(20), .SCORE_W(21)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .char_in     (char_in),
        .char_valid  (char_valid),
        .char_ready  (char_ready),
        .board       (board),
        .board_valid (board_valid),
        .score       (score),
        .score_valid (score_valid),
        .parse_err   (parse_err),
        .tile_cnt    (tile_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    int bv_cnt  = 0;
    int sv_cnt  = 0;
    int pe_cnt  = 0;
    int nr_cnt  = 0;
    int tv[16];
    logic [319:0] exp_board;

    // Pulse / stall counters; each sees the value held during the cycle just ended
    always @(posedge clk) begin
        if (board_valid) bv_cnt++;
        if (score_valid) sv_cnt++;
        if (parse_err)   pe_cnt++;
        if (!char_ready) nr_cnt++;
    end

    task automatic check(input string tag, input logic [319:0] got, input logic [319:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Leaves char_valid high on return (at the negedge after the accepting edge)
    task automatic send_char(input byte c);
        int waited;
        waited = 0;
        char_in    = c;
        char_valid = 1'b1;
        while (!char_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 20) begin
            n_total++;
            n_bad++;
            $display("FAIL ready_timeout: char_ready stuck low, expected high");
        end
        @(negedge clk);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_char(s[i]);
    endtask

    task automatic idle(input int n);
        char_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Printer-style grid; the final '|' is the 16th tile terminator (no trailing newline)
    function automatic string make_frame();
        string s;
        s = "---------------------\n";
        for (int r = 0; r < 4; r++) begin
            s = {s, "|"};
            for (int c = 0; c < 4; c++) s = {s, $sformatf("%4d|", tv[r*4+c])};
            if (r < 3) s = {s, "\n"};
        end
        return s;
    endfunction

    function automatic logic [319:0] model_board();
        logic [319:0] b;
        b = '0;
        for (int k = 0; k < 16; k++) b[k*20 +: 20] = 20'(tv[k]);
        return b;
    endfunction

    int bv0, sv0, pe0, nr0;

    initial begin
        rst_n      = 1'b0;
        char_in    = 8'h00;
        char_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_board", board, '0);
        check("rst_score", 320'(score), 320'd0);
        check("rst_tile_cnt", 320'(tile_cnt), 320'd0);
        check("rst_ready", 320'(char_ready), 320'd1);
        check("rst_pulses", 320'({board_valid, score_valid, parse_err}), 320'd0);
        rst_n = 1'b1;
        idle(2);

        // 1: full frame with latency checks, then score line
        foreach (tv[k]) tv[k] = 0;
        tv[0] = 2; tv[5] = 16; tv[15] = 2048;
        exp_board = model_board();
        bv0 = bv_cnt; sv0 = sv_cnt; pe0 = pe_cnt;
        send_str(make_frame());
        check("t1_commit_ready", 320'(char_ready), 320'd0);
        check("t1_commit_noval", 320'(board_valid), 320'd0);
        char_valid = 1'b0;
        @(negedge clk);
        check("t1_board_valid", 320'(board_valid), 320'd1);
        check("t1_board", board, exp_board);
        check("t1_tile0", 320'(board[19:0]), 320'd2);
        check("t1_tile5", 320'(board[119:100]), 320'd16);
        check("t1_tile15", 320'(board[319:300]), 320'd2048);
        send_str("\nscore: 128\n");
        check("t1_score_valid", 320'(score_valid), 320'd1);
        check("t1_score", 320'(score), 320'd128);
        idle(3);
        check("t1_bv_count", 320'(bv_cnt - bv0), 320'd1);
        check("t1_sv_count", 320'(sv_cnt - sv0), 320'd1);
        check("t1_no_err", 320'(pe_cnt - pe0), 320'd0);

        // 2: tile value limits
        pe0 = pe_cnt;
        send_str("1048575 ");
        idle(1);
        check("t2_max_tile_cnt", 320'(tile_cnt), 320'd1);
        check("t2_max_no_err", 320'(pe_cnt - pe0), 320'd0);
        send_str("1048576 ");
        idle(2);
        check("t2_ovf_err", 320'(pe_cnt - pe0), 320'd1);
        check("t2_ovf_tile_cnt", 320'(tile_cnt), 320'd0);
        check("t2_board_kept", board, exp_board);

        // 3: 7 tiles then junk, then a clean frame
        pe0 = pe_cnt; bv0 = bv_cnt;
        for (int k = 0; k < 7; k++) send_str($sformatf("%4d|", 900 + k));
        send_char(8'h71);
        idle(2);
        check("t3_err", 320'(pe_cnt - pe0), 320'd1);
        check("t3_tile_cnt", 320'(tile_cnt), 320'd0);
        check("t3_board_kept", board, exp_board);
        foreach (tv[k]) tv[k] = k * 3 + 1;
        exp_board = model_board();
        send_str(make_frame());
        idle(3);
        check("t3_board", board, exp_board);
        check("t3_bv_count", 320'(bv_cnt - bv0), 320'd1);

        // 4: back-to-back frame and score with char_valid never dropped
        foreach (tv[k]) tv[k] = 1000 * k + 7;
        exp_board = model_board();
        bv0 = bv_cnt; sv0 = sv_cnt; pe0 = pe_cnt; nr0 = nr_cnt;
        send_str({make_frame(), "score: 77\n"});
        idle(3);
        check("t4_stall_cycles", 320'(nr_cnt - nr0), 320'd1);
        check("t4_board", board, exp_board);
        check("t4_score", 320'(score), 320'd77);
        check("t4_bv_count", 320'(bv_cnt - bv0), 320'd1);
        check("t4_sv_count", 320'(sv_cnt - sv0), 320'd1);
        check("t4_no_err", 320'(pe_cnt - pe0), 320'd0);

        // 5: reset after 9 tiles
        bv0 = bv_cnt;
        for (int k = 0; k < 9; k++) send_str($sformatf("%4d|", k + 1));
        char_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("t5_rst_board", board, '0);
        check("t5_rst_tile_cnt", 320'(tile_cnt), 320'd0);
        check("t5_rst_score", 320'(score), 320'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(3);
        check("t5_no_bv", 320'(bv_cnt - bv0), 320'd0);
        foreach (tv[k]) tv[k] = 1 << k;
        exp_board = model_board();
        send_str(make_frame());
        idle(3);
        check("t5_board", board, exp_board);
        check("t5_bv_count", 320'(bv_cnt - bv0), 320'd1);

        // 6: score value limits
        pe0 = pe_cnt; sv0 = sv_cnt;
        send_str("s 2097152\n");
        idle(2);
        check("t6_ovf_err", 320'(pe_cnt - pe0), 320'd1);
        check("t6_score_kept", 320'(score), 320'd0);
        check("t6_no_sv", 320'(sv_cnt - sv0), 320'd0);
        send_str("score: 2097151\n");
        idle(2);
        check("t6_score_max", 320'(score), 320'd2097151);
        check("t6_sv_count", 320'(sv_cnt - sv0), 320'd1);
        check("t6_board_kept", board, exp_board);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
